// File: rtl/hdlc_rx_frame_demux.sv
// -----------------------------------------------------------------------------
// hdlc_rx_frame_demux
//
// Collects the byte stream coming out of the HDLC deframer (flags and bit
// stuffing already removed) and distributes it by position into NUM_BYTES
// parallel byte registers. Byte index i of a frame lands in slot i of
// data_out. data_out only changes, all at once, when a frame of exactly
// NUM_BYTES bytes ends cleanly; any bad frame leaves the last good one in place.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   byte_in     received byte
//   byte_valid  byte_in valid this cycle
//   sof / eof   first / last byte of frame (qualified by byte_valid)
//   abort       HDLC abort; kills a frame in progress (not qualified)
//   data_out    last good frame, byte i at [DATA_W*i +: DATA_W]
//   frame_valid one-cycle pulse: data_out just updated
//   frame_err   one-cycle pulse: frame discarded
//   err_short   last error was a short frame or abort (held until next outcome)
//   err_long    last error was an overlength frame (held until next outcome)
//   byte_idx    next write index, saturating at NUM_BYTES
//   busy        a frame is in progress (capturing or discarding)
// -----------------------------------------------------------------------------
module hdlc_rx_frame_demux #(
  parameter int NUM_BYTES = 22,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           byte_in,
  input  logic                        byte_valid,
  input  logic                        sof,
  input  logic                        eof,
  input  logic                        abort,
  output logic [NUM_BYTES*DATA_W-1:0] data_out,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic                        err_short,
  output logic                        err_long,
  output logic [CNT_W-1:0]            byte_idx,
  output logic                        busy
);

  // One extra counter bit so the saturated value NUM_BYTES and the "one past
  // the end" comparison are representable even when NUM_BYTES == 2^CNT_W.
  localparam int            IW = CNT_W + 1;
  localparam logic [IW-1:0] NB = IW'(NUM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DISCARD
  } state_e;

  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [IW-1:0]               idx_inc;
  logic [NUM_BYTES*DATA_W-1:0] shadow_q, shadow_d;
  logic [NUM_BYTES*DATA_W-1:0] data_q, data_d;
  logic                        fv_q, fv_d;
  logic                        fe_q, fe_d;
  logic                        es_q, es_d;
  logic                        el_q, el_d;
  logic                        wr_en;
  logic [IW-1:0]               wr_idx;

  assign idx_inc = idx_q + IW'(1);

  // Next-state, counter, pulse and flag logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    es_d    = es_q;
    el_d    = el_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;

    if (abort && state_q != S_IDLE) begin
      // Abort beats any same-cycle byte, including an eof.
      fe_d    = 1'b1;
      es_d    = 1'b1;
      el_d    = 1'b0;
      state_d = S_IDLE;
      idx_d   = '0;
    end else if (byte_valid) begin
      if (sof) begin
        // A new frame always starts at index 0; an unfinished frame is
        // dropped without an error pulse.
        wr_en  = 1'b1;
        wr_idx = '0;
        if (eof) begin
          // One-byte frame: always short since NUM_BYTES >= 2.
          fe_d    = 1'b1;
          es_d    = 1'b1;
          el_d    = 1'b0;
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          state_d = S_CAPTURE;
          idx_d   = IW'(1);
        end
      end else begin
        unique case (state_q)
          S_CAPTURE: begin
            wr_en = (idx_q < NB);
            if (eof) begin
              state_d = S_IDLE;
              idx_d   = '0;
              if (idx_inc == NB) begin
                // Completed frame: publish the shadow including this byte.
                data_d = shadow_d;
                fv_d   = 1'b1;
                es_d   = 1'b0;
                el_d   = 1'b0;
              end else if (idx_inc < NB) begin
                fe_d = 1'b1;
                es_d = 1'b1;
                el_d = 1'b0;
              end else begin
                fe_d = 1'b1;
                es_d = 1'b0;
                el_d = 1'b1;
              end
            end else if (idx_q < NB) begin
              idx_d = idx_inc;
            end else begin
              // Buffer already full and the frame keeps going: it is long.
              state_d = S_DISCARD;
            end
          end
          S_DISCARD: begin
            if (eof) begin
              fe_d    = 1'b1;
              es_d    = 1'b0;
              el_d    = 1'b1;
              state_d = S_IDLE;
              idx_d   = '0;
            end
          end
          default: ;  // IDLE: bytes without sof are ignored
        endcase
      end
    end
  end

  // Shadow buffer write port.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (wr_en && wr_idx == IW'(i)) begin
        shadow_d[i*DATA_W +: DATA_W] = byte_in;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      // NOTE: the shadow buffer is reset too so that nothing left over from
      // before a reset can ever surface; it is small flop storage, not RAM.
      shadow_q <= '0;
      data_q   <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
      es_q     <= 1'b0;
      el_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
      es_q     <= es_d;
      el_q     <= el_d;
    end
  end

  assign data_out    = data_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign err_short   = es_q;
  assign err_long    = el_q;
  assign byte_idx    = idx_q[CNT_W-1:0];
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/hdlc_rx_frame_demux.md
Name: hdlc_rx_frame_demux

Overview:
- Receive-side counterpart of the transmit byte mux: collects a byte stream from the HDLC deframer and distributes bytes by position into NUM_BYTES parallel byte registers.
- Each byte index i lands in output slot i.
- Outputs update atomically only when a frame of exactly NUM_BYTES bytes completes cleanly; otherwise the previous good frame is held.
- Sits between the HDLC bit-level deframer (after flag/stuffing removal) and the register/command decode logic.

Parameters:
NUM_BYTES, 22, frame payload length in bytes; legal 2..32
DATA_W, 8, byte width
CNT_W, 5, width of byte index counter; must satisfy 2^CNT_W >= NUM_BYTES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
byte_in  input  DATA_W  received byte
byte_valid  input  1  byte_in valid this cycle
sof  input  1  qualifies byte_valid: first byte of frame
eof  input  1  qualifies byte_valid: last byte of frame
abort  input  1  HDLC abort detected; kills frame in progress
data_out  output  NUM_BYTES*DATA_W  last good frame; byte i at [DATA_W*i+DATA_W-1 : DATA_W*i]
frame_valid  output  1  one-cycle pulse: data_out just updated
frame_err  output  1  one-cycle pulse: frame discarded
err_short  output  1  sticky-until-next-frame: last error was short frame or abort
err_long  output  1  sticky-until-next-frame: last error was overlength
byte_idx  output  CNT_W  next write index (bytes received in current frame)
busy  output  1  high in CAPTURE or DISCARD

Behaviour:
- Reset (async, any time, including mid-frame):
  - data_out, shadow buffer, byte_idx, frame_valid, frame_err, err_short and err_long all go to 0.
  - State goes to IDLE.
- sof, eof and abort are ignored unless byte_valid is high; abort is the exception and is evaluated every cycle.
- States: IDLE, CAPTURE, DISCARD.
- IDLE:
  - byte_valid&sof: shadow[0]<=byte_in, byte_idx<=1, go to CAPTURE.
  - byte_valid without sof: ignored.
- CAPTURE, byte_valid & !sof & !eof:
  - If byte_idx<NUM_BYTES: shadow[byte_idx]<=byte_in, byte_idx++.
  - Else go to DISCARD; the overflow is flagged at eof.
- CAPTURE, byte_valid & eof (completing byte):
  - The byte counts toward the length; it is written if its index < NUM_BYTES.
  - If byte_idx+1==NUM_BYTES: next cycle data_out<=shadow including this byte, frame_valid=1, err flags cleared.
  - If byte_idx+1<NUM_BYTES: frame_err=1, err_short=1, err_long=0.
  - If byte_idx+1>NUM_BYTES: frame_err=1, err_long=1, err_short=0.
  - In all cases go to IDLE and set byte_idx<=0.
- DISCARD:
  - Consume bytes without writing.
  - On byte_valid&eof: frame_err=1, err_long=1, go to IDLE, byte_idx<=0.
- sof while CAPTURE or DISCARD:
  - Current frame is dropped silently (no frame_err).
  - The new frame starts with this byte at index 0.
- abort while CAPTURE or DISCARD:
  - frame_err=1, err_short=1, go to IDLE, byte_idx<=0.
  - abort has priority over a same-cycle byte_valid/eof.
  - abort in IDLE: no effect.
- sof&eof on the same beat: a 1-byte frame, so frame_err and err_short (NUM_BYTES>=2).
- Latency:
  - frame_valid and frame_err assert exactly 1 cycle after the eof beat.
  - data_out changes in the same cycle as frame_valid.
  - Both pulses last exactly 1 cycle.
- A new sof may arrive on the cycle immediately after eof; back-to-back frames must not lose bytes.
- data_out is never partially updated. Shadow writes during a bad frame never reach data_out.
- byte_idx saturates at NUM_BYTES; overflow bytes are counted only via the DISCARD state.

Test Plan:
- Good frame: send 22 bytes 0x00..0x15 with sof on the first and eof on the last -> 1 cycle after eof, frame_valid=1 for one cycle; data_out byte i == i; frame_err=0.
- Short frame: send 10 bytes, eof on the 10th -> frame_err pulse, err_short=1; data_out unchanged from the previous good frame.
- Long frame: send 25 bytes -> enters DISCARD after byte 22; on eof, frame_err=1 and err_long=1; data_out unchanged; byte_idx=0 afterwards.
- Abort and restart:
  - Abort after byte 7 -> frame_err=1, err_short=1.
  - Then a good frame of 0xA0..0xB5 -> frame_valid; err flags cleared; data_out[7:0]=0xA0.
- Back-to-back with sof mid-frame:
  - Sof at byte 5 of frame A, then 22 bytes 0x55 -> no frame_err for A; frame_valid once; all data_out bytes =0x55.
  - An immediately following frame with sof the cycle after eof is also received correctly.
- Async reset mid-frame: assert rst between clock edges at byte 12 -> all outputs 0 immediately; the next full frame is captured correctly.
